// File: rtl/demux_pkg.sv
// demux_pkg: channel constants and default widths shared by the 1:4 demux and the 4:1 mux.
package demux_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W = 2;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;
  typedef logic [SEL_W-1:0] sel_t;
  localparam sel_t CH_A = 2'b00;
  localparam sel_t CH_B = 2'b01;
  localparam sel_t CH_C = 2'b10;
  localparam sel_t CH_D = 2'b11;
endpackage

// File: rtl/demux4_stream_if.sv
// demux4_stream_if: input stream, four output channels and per-channel beat counters.
interface demux4_stream_if
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) ();
  logic [WIDTH-1:0] in_data;
  sel_t in_sel;
  logic in_valid;
  logic in_ready;
  logic [NUM_CH*WIDTH-1:0] out_data;
  logic [NUM_CH-1:0] out_valid;
  logic [NUM_CH-1:0] out_ready;
  logic [NUM_CH*CNT_W-1:0] beat_cnt;
  modport slave (
    input in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid, beat_cnt
  );
  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input in_ready, out_data, out_valid, beat_cnt
  );
endinterface

// File: rtl/demux_slot.sv
// demux_slot: one-entry output buffer with a delivered-beat counter for a single channel.
module demux_slot #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_ld_data,
  input  logic             i_out_ready,
  output logic             o_out_valid,
  output logic [WIDTH-1:0] o_out_data,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_full_n
);
  logic r_valid;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_cnt;
  logic w_drain;
  assign w_drain = r_valid && i_out_ready;
  // A draining buffer can take a new beat in the same cycle, giving zero-bubble streaming.
  assign o_full_n = !r_valid || i_out_ready;
  assign o_out_valid = r_valid;
  assign o_out_data = r_data;
  assign o_cnt = r_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data <= '0;
      r_cnt <= '0;
    end else begin
      if (i_load) begin
        r_valid <= 1'b1;
        r_data <= i_ld_data;
      end else if (w_drain) begin
        r_valid <= 1'b0;
      end
      if (w_drain) r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/demux4_stream.sv
// demux4_stream: registered 1-to-4 stream demultiplexer with per-channel buffering and counters.
module demux4_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic clk,
  input logic rst,
  demux4_stream_if.slave s_bus
);
  logic [NUM_CH-1:0] w_full_n;
  logic [NUM_CH-1:0] w_load;
  logic [NUM_CH-1:0] w_valid;
  logic [WIDTH-1:0] w_data [NUM_CH];
  logic [CNT_W-1:0] w_cnt [NUM_CH];
  logic w_accept;
  // Only the addressed channel's occupancy gates the input, so a stalled channel blocks nothing else.
  assign s_bus.in_ready = !rst && w_full_n[s_bus.in_sel];
  assign w_accept = s_bus.in_valid && s_bus.in_ready;
  assign s_bus.out_valid = w_valid;
  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    assign w_load[k] = w_accept && (s_bus.in_sel == sel_t'(k));
    demux_slot #(
      .WIDTH(WIDTH),
      .CNT_W(CNT_W)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load[k]),
      .i_ld_data  (s_bus.in_data),
      .i_out_ready(s_bus.out_ready[k]),
      .o_out_valid(w_valid[k]),
      .o_out_data (w_data[k]),
      .o_cnt      (w_cnt[k]),
      .o_full_n   (w_full_n[k])
    );
    assign s_bus.out_data[k*WIDTH +: WIDTH] = w_data[k];
    assign s_bus.beat_cnt[k*CNT_W +: CNT_W] = w_cnt[k];
  end
endmodule
